// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, flit type codes and input framing states.
package noc_pkg;

    localparam int FLIT_WIDTH = 18;

    localparam logic [1:0] FLIT_INV  = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_BODY = 2'b10;
    localparam logic [1:0] FLIT_TAIL = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } frame_state_t;

endpackage

// File: rtl/Memory_async_read_sync_write.sv
// Flit storage array: synchronous write, combinational read, contents cleared by reset.
// Read latency 0 cycles, write visible after the edge; no backpressure of its own.
module Memory_async_read_sync_write #(
    parameter int WIDTH      = 18,
    parameter int LENGTH     = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [WIDTH-1:0]      write_data,
    output logic [WIDTH-1:0]      read_data
);

    logic [WIDTH-1:0] mem [LENGTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LENGTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = read ? mem[read_addr] : '0;

endmodule

// File: rtl/flit_fifo_ctrl.sv
// Router input flit buffer with framing check; first-word-fall-through, flit visible the cycle after its write.
// in_ready = !full (no full bypass); optional registered almost_full under FLIT_FIFO_ALMOST_FULL_EN.
module flit_fifo_ctrl
    import noc_pkg::*;
#(
    parameter int WIDTH      = FLIT_WIDTH,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
`ifdef FLIT_FIFO_ALMOST_FULL_EN
    ,
    parameter int AF_LEVEL   = DEPTH - 2
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  frame_err
`ifdef FLIT_FIFO_ALMOST_FULL_EN
    ,
    output logic                  almost_full
`endif
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] count_d;
    logic [WIDTH-1:0]    rd_data;
    logic [1:0]          flit_type;
    logic                push;
    logic                pop;
    logic                err_set;
    logic                mem_read;
    frame_state_t        state_q;
    frame_state_t        state_d;

    // Wrap bit distinguishes full from empty when the slot addresses coincide.
    assign full      = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                       (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = out_valid ? rd_data : '0;
    assign pop       = out_valid && out_ready;
    assign flit_type = in_data[WIDTH-1 -: 2];
    assign mem_read  = 1'b1;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        err_set = 1'b0;
        if (in_valid && in_ready) begin
            case (state_q)
                ST_IDLE: begin
                    if (flit_type == FLIT_HEAD) begin
                        push    = 1'b1;
                        state_d = ST_IN_PKT;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                ST_IN_PKT: begin
                    if (flit_type == FLIT_BODY) begin
                        push = 1'b1;
                    end else if (flit_type == FLIT_TAIL) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count + PTR_ONE;
            2'b01:   count_d = count - PTR_ONE;
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state_q   <= ST_IDLE;
            frame_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count   <= count_d;
            state_q <= state_d;
            if (err_set) frame_err <= 1'b1;
        end
    end

`ifdef FLIT_FIFO_ALMOST_FULL_EN
    localparam logic [ADDR_WIDTH:0] AF_CNT = AF_LEVEL[ADDR_WIDTH:0];

    // Looks at next count so credit logic sees the threshold one cycle early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) almost_full <= 1'b0;
        else     almost_full <= (count_d >= AF_CNT);
    end
`endif

    Memory_async_read_sync_write #(
        .WIDTH      (WIDTH),
        .LENGTH     (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .read       (mem_read),
        .write      (push),
        .read_addr  (rd_ptr[ADDR_WIDTH-1:0]),
        .write_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .write_data (in_data),
        .read_data  (rd_data)
    );

endmodule

// File: tb/tb_flit_fifo_ctrl.sv
// Bench for flit_fifo_ctrl: directed and randomized steps checked against a queue-based packet model.
module tb_flit_fifo_ctrl;

    localparam int W  = 18;
    localparam int D  = 8;
    localparam int AW = 3;
    localparam int AF = D - 2;

    localparam logic [1:0] T_INV  = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_BODY = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          frame_err;
`ifdef FLIT_FIFO_ALMOST_FULL_EN
    logic          almost_full;
    bit            af_m;
`endif

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] q[$];
    bit           in_pkt_m;
    bit           err_m;

    always #5 clk = ~clk;

    flit_fifo_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .frame_err  (frame_err)
`ifdef FLIT_FIFO_ALMOST_FULL_EN
        ,
        .almost_full(almost_full)
`endif
    );

    function automatic logic [W-1:0] mk(input logic [1:0] tp, input logic [15:0] pl);
        return {tp, pl};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ph);
        logic [W-1:0] head_exp;
        head_exp = (q.size() > 0) ? q[0] : '0;
        check({ph, ":count"},     32'(count),     32'(q.size()));
        check({ph, ":full"},      32'(full),      32'(q.size() == D));
        check({ph, ":empty"},     32'(empty),     32'(q.size() == 0));
        check({ph, ":in_ready"},  32'(in_ready),  32'(q.size() != D));
        check({ph, ":out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        check({ph, ":out_data"},  32'(out_data),  32'(head_exp));
        check({ph, ":frame_err"}, 32'(frame_err), 32'(err_m));
`ifdef FLIT_FIFO_ALMOST_FULL_EN
        check({ph, ":almost_full"}, 32'(almost_full), 32'(af_m));
`endif
    endtask

    // One clock: drive at edge+1, predict from packet rules, compare after the next edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r, input string ph);
        bit         acc;
        bit         pp;
        logic [1:0] tp;
        int         n;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        n   = q.size();
        acc = 0;
        pp  = r && (n > 0);
        tp  = d[W-1:W-2];
        if (v && n < D) begin
            if (!in_pkt_m) begin
                if (tp == T_HEAD) begin acc = 1; in_pkt_m = 1; end
                else err_m = 1;
            end else begin
                if (tp == T_BODY) acc = 1;
                else if (tp == T_TAIL) begin acc = 1; in_pkt_m = 0; end
                else err_m = 1;
            end
        end
        @(posedge clk);
        #1;
        if (pp)  void'(q.pop_front());
        if (acc) q.push_back(d);
`ifdef FLIT_FIFO_ALMOST_FULL_EN
        af_m = (q.size() >= AF);
`endif
        check_outputs(ph);
    endtask

    task automatic do_reset(input string ph);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        q.delete();
        in_pkt_m = 0;
        err_m    = 0;
`ifdef FLIT_FIFO_ALMOST_FULL_EN
        af_m = 0;
`endif
        check_outputs(ph);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset("por");

        // Fill with one full packet, then attempt a ninth push.
        step(1, mk(T_HEAD, 16'h1000), 0, "fill");
        for (int i = 0; i < 6; i++) step(1, mk(T_BODY, 16'(16'h1001 + i)), 0, "fill");
        step(1, mk(T_TAIL, 16'h1007), 0, "fill");
        check("fill_count", 32'(count), 32'd8);
        check("fill_full", 32'(full), 32'd1);
        step(1, mk(T_HEAD, 16'h1ABC), 0, "refuse");

        // Full plus pop: push refused this cycle, accepted the next.
        step(1, mk(T_HEAD, 16'h2000), 1, "full_pop");
        check("full_pop_count", 32'(count), 32'd7);
        step(1, mk(T_HEAD, 16'h2000), 0, "full_push");
        for (int i = 0; i < 8; i++) step(0, '0, 1, "drain");
        check("drain_empty", 32'(empty), 32'd1);

        // Framing errors.
        do_reset("rst_frm");
        step(1, 18'h2_0ABC, 0, "frm_body");
        check("frm_body_err", 32'(frame_err), 32'd1);
        step(1, mk(T_HEAD, 16'h3001), 0, "frm_hht");
        step(1, mk(T_HEAD, 16'h3002), 0, "frm_hht");
        step(1, mk(T_TAIL, 16'h3003), 0, "frm_hht");
        check("frm_hht_count", 32'(count), 32'd2);
        step(1, mk(T_INV, 16'h3004), 0, "frm_inv");

        // Steady push/pop at count 3 across pointer wrap.
        do_reset("rst_sim");
        step(1, mk(T_HEAD, 16'h4000), 0, "sim_pre");
        step(1, mk(T_BODY, 16'h4001), 0, "sim_pre");
        step(1, mk(T_BODY, 16'h4002), 0, "sim_pre");
        for (int i = 0; i < 20; i++) step(1, mk(T_BODY, 16'(16'h4100 + i)), 1, "sim");
        check("sim_count", 32'(count), 32'd3);

        // Reset mid-packet with five flits stored.
        step(1, mk(T_BODY, 16'h4200), 0, "mid");
        step(1, mk(T_BODY, 16'h4201), 0, "mid");
        check("mid_count", 32'(count), 32'd5);
        do_reset("rst_mid");
        step(1, mk(T_BODY, 16'h4300), 0, "post_rst_body");
        check("post_rst_err", 32'(frame_err), 32'd1);

        // Randomized traffic: fill-biased phase, then drain-biased phase.
        do_reset("rst_rnd");
        for (int i = 0; i < 400; i++) begin
            logic [1:0] tp;
            int         sel;
            sel = $urandom_range(0, 9);
            tp  = (sel == 0) ? T_INV : (sel < 3) ? T_HEAD : (sel < 5) ? T_TAIL : T_BODY;
            step(($urandom_range(0, 3) != 0), mk(tp, 16'($urandom)),
                 (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0), "rnd");
        end

`ifdef FLIT_FIFO_ALMOST_FULL_EN
        do_reset("rst_af");
        step(1, mk(T_HEAD, 16'h5000), 0, "af");
        for (int i = 0; i < 4; i++) step(1, mk(T_BODY, 16'(16'h5001 + i)), 0, "af");
        check("af_below", 32'(almost_full), 32'd0);
        step(1, mk(T_BODY, 16'h5005), 0, "af");
        check("af_rise", 32'(almost_full), 32'd1);
        step(0, '0, 1, "af_pop");
        check("af_fall", 32'(almost_full), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
